// File: rtl/decode_stage.sv
// decode_stage: registered RV32I instruction decoder between fetch and execute.
//
// Decodes the incoming instruction word into ALU/comparator/writeback/store
// control fields plus a sign-extended immediate, and holds the result in a
// valid/ready pipeline register. Load-use hazards against the held bundle
// insert a one-cycle bubble. A branch flush kills both the held and the
// incoming instruction.
//
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN
//   defined   : illegal encodings give a valid bundle flagged o_illegal = 1
//   undefined : illegal encodings decode as addi x0, x0, 0 and o_illegal = 0
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_valid / o_ready       upstream handshake (o_ready ignores i_valid)
//   i_instr, i_pc           instruction word and its PC
//   i_flush                 taken branch/jump, kills held and incoming
//   o_valid / i_ready       downstream handshake
//   o_pc, o_rs1, o_rs2, o_rd, o_imm                    registered operands
//   o_alu_op                {funct7[5] for SUB/SRA/SRAI, funct3}, else ADD
//   o_alu_sel1              0 = rs1, 1 = PC, 2 = zero
//   o_alu_sel2              0 = rs2, 1 = immediate
//   o_cmp_op                branch funct3, 0 for non-branches
//   o_is_branch, o_is_jump, o_is_store, o_wb_en, o_wb_sel (0 ALU/1 mem/2 PC+4)
//   o_store_mask, o_mem_funct3, o_illegal

`ifndef ALUOP_WIDTH
`define ALUOP_WIDTH 4
`endif
`ifndef CMPOP_WIDTH
`define CMPOP_WIDTH 3
`endif

module decode_stage #(
  parameter int XLEN    = 32,
  parameter int RF_AW   = 5,
  parameter int ALUOP_W = `ALUOP_WIDTH,
  parameter int CMPOP_W = `CMPOP_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [31:0]        i_instr,
  input  logic [XLEN-1:0]    i_pc,
  input  logic               i_flush,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [XLEN-1:0]    o_pc,
  output logic [RF_AW-1:0]   o_rs1,
  output logic [RF_AW-1:0]   o_rs2,
  output logic [RF_AW-1:0]   o_rd,
  output logic [XLEN-1:0]    o_imm,
  output logic [ALUOP_W-1:0] o_alu_op,
  output logic [1:0]         o_alu_sel1,
  output logic [1:0]         o_alu_sel2,
  output logic [CMPOP_W-1:0] o_cmp_op,
  output logic               o_is_branch,
  output logic               o_is_jump,
  output logic               o_is_store,
  output logic               o_wb_en,
  output logic [1:0]         o_wb_sel,
  output logic [3:0]         o_store_mask,
  output logic [2:0]         o_mem_funct3,
  output logic               o_illegal
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [31:0]        imm_i, imm_s, imm_b, imm_u, imm_j;

  logic               legal;
  logic [RF_AW-1:0]   d_rs1, d_rs2, d_rd;
  logic [31:0]        d_imm;
  logic [3:0]         d_alu;
  logic [1:0]         d_sel1, d_sel2, d_wb_sel;
  logic [2:0]         d_cmp, d_mem_f3;
  logic               d_branch, d_jump, d_store, d_writes, d_wb_en, d_illegal;
  logic [3:0]         d_mask;
  logic               hazard;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];
  assign funct7 = i_instr[31:25];

  assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                  i_instr[11:8], 1'b0};
  assign imm_u = {i_instr[31:12], 12'h000};
  assign imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                  i_instr[30:21], 1'b0};

  // Combinational decode. Defaults are the addi x0, x0, 0 controls so that
  // any field a format does not use reads as zero, and an illegal encoding
  // can simply fall back to the defaults.
  always_comb begin
    legal    = 1'b0;
    d_rs1    = '0;
    d_rs2    = '0;
    d_rd     = '0;
    d_imm    = '0;
    d_alu    = 4'd0;
    d_sel1   = 2'd0;
    d_sel2   = 2'd1;
    d_cmp    = 3'd0;
    d_branch = 1'b0;
    d_jump   = 1'b0;
    d_store  = 1'b0;
    d_writes = 1'b0;
    d_wb_sel = 2'd0;
    d_mask   = 4'b0000;
    d_mem_f3 = 3'd0;
    case (opcode)
      7'b0110111: begin // LUI: zero + imm
        legal = 1'b1; d_rd = RF_AW'(i_instr[11:7]); d_imm = imm_u;
        d_sel1 = 2'd2; d_writes = 1'b1;
      end
      7'b0010111: begin // AUIPC: pc + imm
        legal = 1'b1; d_rd = RF_AW'(i_instr[11:7]); d_imm = imm_u;
        d_sel1 = 2'd1; d_writes = 1'b1;
      end
      7'b1101111: begin // JAL: ALU forms the target, rd gets PC+4
        legal = 1'b1; d_rd = RF_AW'(i_instr[11:7]); d_imm = imm_j;
        d_sel1 = 2'd1; d_jump = 1'b1; d_writes = 1'b1; d_wb_sel = 2'd2;
      end
      7'b1100111: begin // JALR
        legal = (funct3 == 3'd0); d_rd = RF_AW'(i_instr[11:7]);
        d_rs1 = RF_AW'(i_instr[19:15]); d_imm = imm_i;
        d_jump = 1'b1; d_writes = 1'b1; d_wb_sel = 2'd2;
      end
      7'b1100011: begin // branches: ALU forms pc + imm, comparator uses funct3
        legal = (funct3 != 3'd2) && (funct3 != 3'd3);
        d_rs1 = RF_AW'(i_instr[19:15]); d_rs2 = RF_AW'(i_instr[24:20]);
        d_imm = imm_b; d_sel1 = 2'd1; d_cmp = funct3; d_branch = 1'b1;
      end
      7'b0000011: begin // loads
        legal = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
        d_rd = RF_AW'(i_instr[11:7]); d_rs1 = RF_AW'(i_instr[19:15]);
        d_imm = imm_i; d_writes = 1'b1; d_wb_sel = 2'd1; d_mem_f3 = funct3;
      end
      7'b0100011: begin // stores; mask is unshifted, byte lane 0 upward
        legal = (funct3 <= 3'd2);
        d_rs1 = RF_AW'(i_instr[19:15]); d_rs2 = RF_AW'(i_instr[24:20]);
        d_imm = imm_s; d_store = 1'b1; d_mem_f3 = funct3;
        d_mask = (funct3 == 3'd0) ? 4'b0001 :
                 (funct3 == 3'd1) ? 4'b0011 : 4'b1111;
      end
      7'b0010011: begin // OP-IMM; shifts constrain imm[11:5]
        legal = (funct3 == 3'd1) ? (funct7 == 7'h00) :
                (funct3 == 3'd5) ? ((funct7 == 7'h00) || (funct7 == 7'h20)) :
                1'b1;
        d_rd = RF_AW'(i_instr[11:7]); d_rs1 = RF_AW'(i_instr[19:15]);
        d_imm = imm_i; d_writes = 1'b1;
        d_alu = {(funct3 == 3'd5) && i_instr[30], funct3};
      end
      7'b0110011: begin // OP; funct7 = 0x20 only for SUB and SRA
        legal = (funct7 == 7'h00) ||
                ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
        d_rd = RF_AW'(i_instr[11:7]); d_rs1 = RF_AW'(i_instr[19:15]);
        d_rs2 = RF_AW'(i_instr[24:20]); d_sel2 = 2'd0; d_writes = 1'b1;
        d_alu = {i_instr[30], funct3};
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      d_rs1    = '0;
      d_rs2    = '0;
      d_rd     = '0;
      d_imm    = '0;
      d_alu    = 4'd0;
      d_sel1   = 2'd0;
      d_sel2   = 2'd1;
      d_cmp    = 3'd0;
      d_branch = 1'b0;
      d_jump   = 1'b0;
      d_store  = 1'b0;
      d_writes = 1'b0;
      d_wb_sel = 2'd0;
      d_mask   = 4'b0000;
      d_mem_f3 = 3'd0;
    end

    d_wb_en = d_writes && (d_rd != '0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    d_illegal = !legal;
`else
    d_illegal = 1'b0;
`endif
  end

  // Load-use: the held bundle is a load whose result the incoming
  // instruction needs. Unused source fields decode to x0 and never match.
  assign hazard = o_valid && (o_wb_sel == 2'd1) && (o_rd != '0) &&
                  ((d_rs1 == o_rd) || (d_rs2 == o_rd));

  assign o_ready = i_rst_n && !hazard && (!o_valid || i_ready);

  // Pipeline register. Flush beats hold beats the hazard bubble; a flushed
  // or bubbled cycle only clears o_valid, data fields are left as they are.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid      <= 1'b0;
      o_pc         <= '0;
      o_rs1        <= '0;
      o_rs2        <= '0;
      o_rd         <= '0;
      o_imm        <= '0;
      o_alu_op     <= '0;
      o_alu_sel1   <= '0;
      o_alu_sel2   <= '0;
      o_cmp_op     <= '0;
      o_is_branch  <= 1'b0;
      o_is_jump    <= 1'b0;
      o_is_store   <= 1'b0;
      o_wb_en      <= 1'b0;
      o_wb_sel     <= '0;
      o_store_mask <= '0;
      o_mem_funct3 <= '0;
      o_illegal    <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (o_valid && !i_ready) begin
      o_valid <= 1'b1;
    end else if (hazard) begin
      o_valid <= 1'b0;
    end else if (i_valid) begin
      o_valid      <= 1'b1;
      o_pc         <= i_pc;
      o_rs1        <= d_rs1;
      o_rs2        <= d_rs2;
      o_rd         <= d_rd;
      o_imm        <= XLEN'($signed(d_imm));
      o_alu_op     <= ALUOP_W'(d_alu);
      o_alu_sel1   <= d_sel1;
      o_alu_sel2   <= d_sel2;
      o_cmp_op     <= CMPOP_W'(d_cmp);
      o_is_branch  <= d_branch;
      o_is_jump    <= d_jump;
      o_is_store   <= d_store;
      o_wb_en      <= d_wb_en;
      o_wb_sel     <= d_wb_sel;
      o_store_mask <= d_mask;
      o_mem_funct3 <= d_mem_f3;
      o_illegal    <= d_illegal;
    end else begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized scoreboard bench for decode_stage.
// A driver applies one cycle of stimulus at a time, predicts o_ready and
// o_valid from a bundle-level pipeline model, and pushes the expected decoded
// bundle on each accepted, unflushed instruction. A monitor compares every
// presented bundle against the queue head and pops it on transfer.

module tb_decode_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_instr;
  logic [31:0] i_pc;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_pc;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [31:0] o_imm;
  logic [3:0]  o_alu_op;
  logic [1:0]  o_alu_sel1, o_alu_sel2;
  logic [2:0]  o_cmp_op;
  logic        o_is_branch, o_is_jump, o_is_store, o_wb_en;
  logic [1:0]  o_wb_sel;
  logic [3:0]  o_store_mask;
  logic [2:0]  o_mem_funct3;
  logic        o_illegal;

  decode_stage #(.XLEN(32), .RF_AW(5), .ALUOP_W(4), .CMPOP_W(3)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(i_instr), .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid),
    .i_ready(i_ready), .o_pc(o_pc), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd),
    .o_imm(o_imm), .o_alu_op(o_alu_op), .o_alu_sel1(o_alu_sel1),
    .o_alu_sel2(o_alu_sel2), .o_cmp_op(o_cmp_op), .o_is_branch(o_is_branch),
    .o_is_jump(o_is_jump), .o_is_store(o_is_store), .o_wb_en(o_wb_en),
    .o_wb_sel(o_wb_sel), .o_store_mask(o_store_mask),
    .o_mem_funct3(o_mem_funct3), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  typedef enum {F_R, F_I, F_S, F_B, F_U, F_J} fmt_t;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic [1:0]  sel1, sel2;
    logic [2:0]  cmp;
    logic        branch, jump, store, wb_en, is_load, illegal;
    logic [1:0]  wb_sel;
    logic [3:0]  mask;
    logic [2:0]  mem_f3;
    logic        use1, use2, chk_imm, chk_mem, partial;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        m_valid = 1'b0;
  logic [4:0]  m_rd = 5'd0;
  logic        m_is_load = 1'b0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // RV32I legality by opcode class and the funct fields that matter.
  function automatic logic isLegal(input logic [31:0] ins);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ins[14:12];
    f7 = ins[31:25];
    case (ins[6:0])
      7'h37, 7'h17, 7'h6F: return 1'b1;
      7'h67: return f3 == 3'd0;
      7'h63: return !(f3 inside {3'd2, 3'd3});
      7'h03: return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      7'h23: return f3 <= 3'd2;
      7'h13: return (f3 == 3'd1) ? (f7 == 7'h00) :
                    (f3 == 3'd5) ? (f7 inside {7'h00, 7'h20}) : 1'b1;
      7'h33: return (f7 == 7'h00) || (f7 == 7'h20 && f3 inside {3'd0, 3'd5});
      default: return 1'b0;
    endcase
  endfunction

  // Reference decode: classify into an instruction format, derive register
  // usage and immediate from the format, then add per-opcode controls.
  // Illegal words are decoded as the canonical NOP 0x00000013.
  function automatic exp_t refDecode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t        e;
    logic        ok;
    logic [31:0] w;
    logic [6:0]  op;
    logic [2:0]  f3;
    fmt_t        fmt;
    logic        has_rd;
    ok = isLegal(ins);
    w  = ok ? ins : 32'h0000_0013;
    op = w[6:0];
    f3 = w[14:12];
    case (op)
      7'h33:               fmt = F_R;
      7'h23:               fmt = F_S;
      7'h63:               fmt = F_B;
      7'h37, 7'h17:        fmt = F_U;
      7'h6F:               fmt = F_J;
      default:             fmt = F_I;
    endcase
    e.pc     = pc;
    e.use1   = fmt inside {F_R, F_I, F_S, F_B};
    e.use2   = fmt inside {F_R, F_S, F_B};
    has_rd   = fmt inside {F_R, F_I, F_U, F_J};
    e.rs1    = e.use1 ? w[19:15] : 5'd0;
    e.rs2    = e.use2 ? w[24:20] : 5'd0;
    e.rd     = has_rd ? w[11:7] : 5'd0;
    case (fmt)
      F_I:     e.imm = 32'($signed(w[31:20]));
      F_S:     e.imm = 32'($signed({w[31:25], w[11:7]}));
      F_B:     e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      F_U:     e.imm = {w[31:12], 12'h000};
      F_J:     e.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      default: e.imm = 32'd0;
    endcase
    e.chk_imm = (fmt != F_R);
    e.alu_op  = (op == 7'h33) ? {w[30], f3} :
                (op == 7'h13) ? {(f3 == 3'd5) && w[30], f3} : 4'd0;
    e.sel1    = (op == 7'h37) ? 2'd2 : (op inside {7'h17, 7'h6F, 7'h63}) ? 2'd1 : 2'd0;
    e.sel2    = (fmt == F_R) ? 2'd0 : 2'd1;
    e.branch  = (op == 7'h63);
    e.cmp     = e.branch ? f3 : 3'd0;
    e.jump    = (op inside {7'h6F, 7'h67});
    e.store   = (op == 7'h23);
    e.is_load = (op == 7'h03);
    e.wb_sel  = e.is_load ? 2'd1 : e.jump ? 2'd2 : 2'd0;
    e.wb_en   = has_rd && (e.rd != 5'd0);
    e.mask    = e.store ? 4'((1 << (1 << f3)) - 1) : 4'd0;
    e.chk_mem = e.store || e.is_load;
    e.mem_f3  = f3;
`ifdef DECODE_ILLEGAL_TRAP_EN
    e.illegal = !ok;
    e.partial = !ok;
`else
    e.illegal = 1'b0;
    e.partial = 1'b0;
`endif
    return e;
  endfunction

  function automatic logic [31:0] genInstr();
    logic [31:0] w;
    logic [6:0]  opcs [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    int          k;
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k == 9) return w;
    w[6:0]   = opcs[k];
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    if (k >= 7) begin
      case ($urandom_range(0, 3))
        0, 1:    w[31:25] = 7'h00;
        2:       w[31:25] = 7'h20;
        default: w[31:25] = w[31:25];
      endcase
    end
    return w;
  endfunction

  // One cycle of stimulus, entered and left at posedge + 1.
  task automatic applyStimulus(input logic v, input logic [31:0] ins,
                               input logic rdy, input logic fl);
    exp_t e;
    logic hz, exp_rdy;
    i_valid = v;
    i_instr = ins;
    i_pc    = pc_ctr;
    i_ready = rdy;
    i_flush = fl;
    e  = refDecode(ins, pc_ctr);
    hz = m_valid && m_is_load && (m_rd != 5'd0) &&
         ((e.use1 && e.rs1 == m_rd) || (e.use2 && e.rs2 == m_rd));
    exp_rdy = !hz && (!m_valid || rdy);
    @(negedge i_clk);
    #1;
    checkOutput("o_ready", 64'(o_ready), 64'(exp_rdy));
    checkOutput("o_valid", 64'(o_valid), 64'(m_valid));
    if (fl) begin
      if (m_valid && !rdy && sb.size() > 0) void'(sb.pop_front());
      m_valid = 1'b0;
    end else if (m_valid && !rdy) begin
      m_valid = 1'b1;
    end else if (hz) begin
      m_valid = 1'b0;
    end else if (v) begin
      sb.push_back(e);
      m_valid   = 1'b1;
      m_rd      = e.rd;
      m_is_load = e.is_load;
    end else begin
      m_valid = 1'b0;
    end
    if (v && exp_rdy) pc_ctr = pc_ctr + 32'd4;
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: compare every presented bundle with the head; pop on transfer.
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_bundle_pc", 64'(o_pc), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = sb[0];
        checkOutput("pc", 64'(o_pc), 64'(e.pc));
        checkOutput("illegal", 64'(o_illegal), 64'(e.illegal));
        checkOutput("wb_en", 64'(o_wb_en), 64'(e.wb_en));
        checkOutput("is_store", 64'(o_is_store), 64'(e.store));
        checkOutput("is_branch", 64'(o_is_branch), 64'(e.branch));
        checkOutput("is_jump", 64'(o_is_jump), 64'(e.jump));
        if (!e.partial) begin
          checkOutput("rs1", 64'(o_rs1), 64'(e.rs1));
          checkOutput("rs2", 64'(o_rs2), 64'(e.rs2));
          checkOutput("rd", 64'(o_rd), 64'(e.rd));
          checkOutput("wb_sel", 64'(o_wb_sel), 64'(e.wb_sel));
          checkOutput("alu_op", 64'(o_alu_op), 64'(e.alu_op));
          checkOutput("alu_sel1", 64'(o_alu_sel1), 64'(e.sel1));
          checkOutput("alu_sel2", 64'(o_alu_sel2), 64'(e.sel2));
          checkOutput("cmp_op", 64'(o_cmp_op), 64'(e.cmp));
          checkOutput("store_mask", 64'(o_store_mask), 64'(e.mask));
          if (e.chk_imm) checkOutput("imm", 64'(o_imm), 64'(e.imm));
          if (e.chk_mem) checkOutput("mem_funct3", 64'(o_mem_funct3), 64'(e.mem_f3));
        end
        if (i_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_instr = 32'd0;
    i_pc    = 32'd0;
    i_ready = 1'b0;
    i_flush = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("reset_o_valid", 64'(o_valid), 64'd0);
    checkOutput("reset_o_ready", 64'(o_ready), 64'd0);
    checkOutput("reset_o_illegal", 64'(o_illegal), 64'd0);
    checkOutput("reset_o_pc", 64'(o_pc), 64'd0);
    checkOutput("reset_o_imm", 64'(o_imm), 64'd0);
    checkOutput("reset_o_wb_en", 64'(o_wb_en), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    $display("[TB] directed sequence");
    applyStimulus(1'b1, 32'h0070_0293, 1'b1, 1'b0); // addi x5, x0, 7
    applyStimulus(1'b1, 32'hFE20_AE23, 1'b1, 1'b0); // sw x2, -4(x1)
    applyStimulus(1'b1, 32'h0000_A183, 1'b1, 1'b0); // lw x3, 0(x1)
    applyStimulus(1'b1, 32'h0031_8233, 1'b1, 1'b0); // add x4, x3, x3 (bubble)
    applyStimulus(1'b1, 32'h0031_8233, 1'b1, 1'b0); // add accepted
    applyStimulus(1'b1, 32'h0010_0313, 1'b1, 1'b0); // addi x6, x0, 1
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'h0020_0393, 1'b0, 1'b0); // addi x7, x0, 2 held off
    applyStimulus(1'b1, 32'h0020_0393, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0020_8463, 1'b1, 1'b1); // beq with flush
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0); // illegal encoding
    applyStimulus(1'b0, 32'h0000_0000, 1'b1, 1'b0);

    $display("[TB] random sequence");
    for (int i = 0; i < 2000; i++)
      applyStimulus(($urandom % 4) != 0, genInstr(), ($urandom % 4) != 0,
                    ($urandom % 16) == 0);

    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 32'h0000_0000, 1'b1, 1'b0);
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("[TB] reset during hold");
    applyStimulus(1'b1, 32'h0070_0293, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0000_0000, 1'b0, 1'b0);
    i_rst_n = 1'b0;
    #1;
    checkOutput("midhold_reset_o_valid", 64'(o_valid), 64'd0);
    checkOutput("midhold_reset_o_ready", 64'(o_ready), 64'd0);
    sb.delete();
    m_valid = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    applyStimulus(1'b0, 32'h0000_0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0000_0000, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
